// File: rtl/msu_pkg.sv
// Shared MSU definitions: data-port FSM states, default sizes and MSU_STATUS bit positions.
package msu_pkg;

   typedef enum logic [0:0] {
      MSU_D_IDLE = 1'b0,
      MSU_D_REQ  = 1'b1
   } msu_d_state_e;

   localparam int unsigned MSU_FIFO_AW_DEF = 3;
   localparam int unsigned MSU_ADDR_W_DEF  = 32;
   localparam int unsigned MSU_BYTE_W      = 8;

   // MSU_STATUS bit indices, shared with the register block
   localparam int unsigned MSU_STATUS_DATA_BUSY_BIT     = 7;
   localparam int unsigned MSU_STATUS_AUDIO_BUSY_BIT    = 6;
   localparam int unsigned MSU_STATUS_AUDIO_REPEAT_BIT  = 5;
   localparam int unsigned MSU_STATUS_AUDIO_PLAYING_BIT = 4;
   localparam int unsigned MSU_STATUS_TRACK_MISSING_BIT = 3;

endpackage

// File: rtl/msu_data_ctrl_if.sv
// Register-block and backing-store signals of the MSU data port.
interface msu_data_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              seek_valid;
   logic [ADDR_W-1:0] seek_addr;
   logic              rd_pulse;
   logic [7:0]        data_out;
   logic              data_busy;
   logic              underrun;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_data;

   // slave: the data controller; master: register block plus backing store
   modport slave (
      input  seek_valid, seek_addr, rd_pulse, mem_ack, mem_data,
      output data_out, data_busy, underrun, mem_req, mem_addr
   );

   modport master (
      output seek_valid, seek_addr, rd_pulse, mem_ack, mem_data,
      input  data_out, data_busy, underrun, mem_req, mem_addr
   );
endinterface

// File: rtl/msu_byte_fifo.sv
// Synchronous byte FIFO; flush beats push/pop. head_o is the head as it will be after this cycle.
module msu_byte_fifo #(
   parameter int unsigned AW = 3,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] head_o,
   output logic          nxt_empty_o,
   output logic [AW:0]   count_o,
   output logic          empty_o
);
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned CW    = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign do_push    = push_i && !flush_i && (count_q != CW'(DEPTH));
   assign do_pop     = pop_i && !flush_i && !empty_o;
   assign rd_ptr_nxt = rd_ptr_q + AW'(1);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_o   = mem_q[rd_ptr_q];
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_nxt;
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
      // a byte pushed into a FIFO that is (or is becoming) empty is the new head
      if (do_pop) head_o = (count_q == CW'(1)) ? wdata_i : mem_q[rd_ptr_nxt];
      else if (empty_o) head_o = wdata_i;
   end

   assign nxt_empty_o = (count_d == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end
endmodule

// File: rtl/msu_data_ctrl.sv
// MSU-1 data port sequencer: seek handling, single-outstanding prefetch into a byte FIFO, $2001 data.
module msu_data_ctrl
   import msu_pkg::*;
#(
   parameter int unsigned FIFO_AW = MSU_FIFO_AW_DEF,
   parameter int unsigned ADDR_W  = MSU_ADDR_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   msu_data_ctrl_if.slave bus
);
   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CW    = FIFO_AW + 1;

   msu_d_state_e      state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic              armed_q, armed_d;
   logic              discard_q, discard_d;
   logic [7:0]        data_out_q, data_out_d;
   logic              busy_q, busy_d;
   logic              underrun_q, underrun_d;

   logic              seek, ack, push, pop;
   logic [7:0]        fifo_head;
   logic              fifo_nxt_empty, fifo_empty;
   logic [CW-1:0]     fifo_count;

   assign seek = bus.seek_valid;
   assign ack  = bus.mem_ack && (state_q == MSU_D_REQ);
   // a seek flushes the FIFO, so it overrides any pop in the same cycle
   assign pop  = bus.rd_pulse && !seek && !fifo_empty && !busy_q;

   msu_byte_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (seek),
      .push_i      (push),
      .wdata_i     (bus.mem_data),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .nxt_empty_o (fifo_nxt_empty),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty)
   );

   // next-state: fetch FSM, address counter, flags and presented byte
   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      fetch_addr_d = fetch_addr_q;
      armed_d      = armed_q;
      discard_d    = discard_q;
      push         = 1'b0;

      unique case (state_q)
         MSU_D_IDLE: begin
            if (armed_q && (fifo_count < CW'(DEPTH)) && !seek) begin
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_addr_q;
               state_d    = MSU_D_REQ;
            end
         end
         MSU_D_REQ: begin
            if (ack) begin
               mem_req_d = 1'b0;
               discard_d = 1'b0;
               state_d   = MSU_D_IDLE;
               if (!discard_q && !seek) begin
                  push         = 1'b1;
                  fetch_addr_d = fetch_addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = MSU_D_IDLE;
      endcase

      // the in-flight request cannot be withdrawn, so its byte is marked stale instead
      if (seek) begin
         fetch_addr_d = bus.seek_addr;
         armed_d      = 1'b1;
         if ((state_q == MSU_D_REQ) && !ack) discard_d = 1'b1;
      end

      busy_d     = seek ? 1'b1 : (push ? 1'b0 : busy_q);
      underrun_d = seek ? 1'b0
                 : ((bus.rd_pulse && (fifo_empty || busy_q)) ? 1'b1 : underrun_q);
      data_out_d = fifo_nxt_empty ? data_out_q : fifo_head;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= MSU_D_IDLE;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         fetch_addr_q <= '0;
         armed_q      <= 1'b0;
         discard_q    <= 1'b0;
         data_out_q   <= '0;
         busy_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         fetch_addr_q <= fetch_addr_d;
         armed_q      <= armed_d;
         discard_q    <= discard_d;
         data_out_q   <= data_out_d;
         busy_q       <= busy_d;
         underrun_q   <= underrun_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.data_out  = data_out_q;
   assign bus.data_busy = busy_q;
   assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_msu_data_ctrl.sv
// Bench for msu_data_ctrl: directed scenarios plus random traffic against a queue-based reference.
module tb_msu_data_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   msu_data_ctrl_if #(.ADDR_W(32)) bus ();

   msu_data_ctrl #(.FIFO_AW(3), .ADDR_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // reference state: buffered bytes and transaction-level view of the port
   byte unsigned mq[$];
   logic [31:0] m_fa, m_raddr;
   bit   m_armed, m_disc, m_out, m_busy, m_und;
   logic [7:0] m_dout;

   // backing-store responder
   bit pending;
   int cnt;
   int ack_dly;
   bit rand_dly;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_fa = '0; m_raddr = '0; m_armed = 0; m_disc = 0; m_out = 0;
      m_busy = 0; m_und = 0; m_dout = '0;
      pending = 0; cnt = 0;
   endtask

   task automatic model_update(input bit sk, input logic [31:0] sa, input bit rd, input bit a);
      int  n0;
      bit  ackv, push, pop, out0;
      logic [7:0] d;
      n0   = mq.size();
      out0 = m_out;
      ackv = a && m_out;
      d    = m_raddr[7:0];
      push = ackv && !m_disc && !sk;
      pop  = rd && !sk && (n0 > 0) && !m_busy;
      if (sk) m_und = 0;
      else if (rd && (n0 == 0 || m_busy)) m_und = 1;
      if (sk) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(d);
      end
      if (mq.size() > 0) m_dout = mq[0];
      if (sk) m_busy = 1;
      else if (push) m_busy = 0;
      if (m_out) begin
         if (ackv) m_out = 0;
      end else if (m_armed && n0 < 8 && !sk) begin
         m_out   = 1;
         m_raddr = m_fa;
      end
      if (ackv) m_disc = 0;
      else if (sk && out0) m_disc = 1;
      if (push) m_fa = m_fa + 32'd1;
      if (sk) begin
         m_fa    = sa;
         m_armed = 1;
      end
   endtask

   task automatic check_all();
      check("mem_req", 32'(bus.mem_req), 32'(m_out));
      if (m_out) check("mem_addr", bus.mem_addr, m_raddr);
      check("data_out", 32'(bus.data_out), 32'(m_dout));
      check("data_busy", 32'(bus.data_busy), 32'(m_busy));
      check("underrun", 32'(bus.underrun), 32'(m_und));
   endtask

   // one clock: drive inputs, advance the reference, sample #1 after the edge
   task automatic step(input bit sk, input logic [31:0] sa, input bit rd);
      bit a;
      a = 0;
      if (!pending && bus.mem_req) begin
         pending = 1;
         cnt = rand_dly ? int'($urandom_range(0, 6)) : ack_dly;
      end
      if (pending) begin
         if (cnt == 0) begin
            a = 1;
            pending = 0;
         end else cnt--;
      end
      bus.seek_valid = sk;
      bus.seek_addr  = sa;
      bus.rd_pulse   = rd;
      bus.mem_ack    = a;
      bus.mem_data   = a ? bus.mem_addr[7:0] : 8'h00;
      @(posedge clk);
      model_update(sk, sa, rd, a);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0);
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      bus.seek_valid = 0; bus.seek_addr = '0; bus.rd_pulse = 0;
      bus.mem_ack = 0; bus.mem_data = '0;
      ack_dly = 3; rand_dly = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_data_out", 32'(bus.data_out), 32'd0);
      check("rst_data_busy", 32'(bus.data_busy), 32'd0);
      check("rst_underrun", 32'(bus.underrun), 32'd0);
      rst_n = 1'b1;

      // nothing is fetched before the first seek
      idle(5);

      // fill from 0x1000 until 8 bytes are buffered, then confirm it stays quiet
      step(1, 32'h0000_1000, 0);
      idle(60);
      check("fill_level", 32'(mq.size()), 32'd8);
      idle(5);

      // drain with spaced reads; refills continue from 0x1008
      for (int i = 0; i < 8; i++) begin
         step(0, '0, 1);
         idle(3);
      end
      idle(20);

      // seek while the request for 0x1003 is outstanding
      ack_dly = 5;
      step(1, 32'h0000_1000, 0);
      k = 0;
      while (!(bus.mem_req && bus.mem_addr == 32'h0000_1003) && k < 100) begin
         step(0, '0, 0);
         k++;
      end
      check("wait_req_1003", bus.mem_addr, 32'h0000_1003);
      step(1, 32'h0000_2000, 0);
      idle(40);

      // read right after a seek, then a second seek clears the sticky flag
      ack_dly = 2;
      step(1, 32'h0000_3000, 0);
      step(0, '0, 1);
      check("underrun_set", 32'(bus.underrun), 32'd1);
      step(1, 32'h0000_3100, 0);
      check("underrun_clr", 32'(bus.underrun), 32'd0);
      idle(30);

      // address counter wraps modulo 2^32
      ack_dly = 1;
      step(1, 32'hFFFF_FFFE, 0);
      idle(30);
      for (int i = 0; i < 4; i++) step(0, '0, 1);
      idle(10);

      // asynchronous reset while a request is outstanding
      ack_dly = 6;
      step(1, 32'h0000_4000, 0);
      k = 0;
      while (!bus.mem_req && k < 20) begin
         step(0, '0, 0);
         k++;
      end
      check("wait_req_4000", 32'(bus.mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_mem_req", 32'(bus.mem_req), 32'd0);
      check("arst_data_busy", 32'(bus.data_busy), 32'd0);
      check("arst_data_out", 32'(bus.data_out), 32'd0);
      check("arst_underrun", 32'(bus.underrun), 32'd0);
      model_reset();
      bus.mem_ack = 0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(10);

      // random traffic: seeks, reads and variable ack latency
      rand_dly = 1;
      for (int i = 0; i < 2000; i++) begin
         bit sk, rd;
         logic [31:0] sa;
         sk = ($urandom_range(0, 39) == 0);
         rd = ($urandom_range(0, 2) == 0);
         sa = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom);
         step(sk, sa, rd);
      end
      idle(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
